rr_arbiter_4: RTL and testbench
===============================

Name: rr_arbiter_4

Overview:
- Round-robin arbiter that shares one 4-way resource among four requesters.
- Produces a registered one-hot grant, matching the 2-to-4 decode form, plus the binary index and a valid flag.
- Downstream logic steers the shared datapath with the grant.
- Sits between requesting agents and the decoder-selected resource.
- Enforces fairness and a bounded hold time.

Parameters:
- MAX_HOLD, 8: maximum consecutive cycles one holder keeps the grant while another requester waits. 0 = unlimited. Legal range 0..255.
- CNT_W, 8: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  arbiter enable. 0 revokes the current grant and blocks new grants.
- req  input  4  request vector; bit i = requester i. Level-sensitive, held while the resource is needed.
- grant  output  4  registered one-hot grant. All zero when nothing is granted.
- grant_idx  output  2  binary index of the holder. Holds the last value when grant_valid=0.
- grant_valid  output  1  high whenever grant is non-zero.

Behaviour:
Reset (rst=1 at an edge), regardless of en and req:
- grant=4'b0000, grant_idx=2'b00, grant_valid=0.
- state=IDLE, hold_cnt=0.
- Priority pointer last=3, so the first search starts at requester 0.

States: IDLE (no holder) and GRANT (holder h = grant_idx).

Search rule:
- Pick the first i with req[i]=1, scanning (last+1), (last+2), (last+3), (last+4) mod 4.
- The scan wraps 3 -> 0.

IDLE:
- If en=1 and req!=0 at an edge: apply the search rule and load grant=1<<i, grant_idx=i, grant_valid=1, hold_cnt=0, then go to GRANT.
- Latency: req sampled at edge N gives grant visible after edge N, i.e. one cycle.

GRANT, evaluated in priority order at each edge:
1. en=0: grant=0, grant_valid=0, go to IDLE. Set last=h, so the revoked holder gets lowest priority next time.
2. req[h]=0 (release): set last=h.
   - If other requests are pending, grant the next one per the search rule on the same edge, with no bubble cycle, and hold_cnt=0.
   - Otherwise grant=0, grant_valid=0, go to IDLE.
3. MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, and any req[j]=1 for j!=h (forced rotation): set last=h and grant the next requester per the search rule, hold_cnt=0.
4. Otherwise keep the grant. hold_cnt increments, saturating at MAX_HOLD-1. With no competing requester the holder keeps the grant indefinitely.

Boundary rules:
- Release and forced rotation on the same edge is treated as a release; the result is identical.
- Holder drops req for one cycle and re-raises it: treated as a release; the holder re-queues behind the others.
- A single requester always wins regardless of pointer.
- req=4'b1111 steady with MAX_HOLD=N: the grant order is 0,1,2,3,0,… and each holder keeps the grant exactly N cycles.
- rst mid-grant: the grant drops after that edge, and the pointer returns to 3.

Invariants:
- grant always has at most one bit set.
- grant_valid == |grant.
- When valid, grant == 1<<grant_idx.
- All outputs are registered; there are no combinational paths from req or en to the outputs.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, req=0000, en=1 -> grant=0000, grant_valid=0, grant_idx=00 for 5 cycles.
- Single request: en=1, req=0100 asserted at edge N -> grant=0100, grant_idx=10 after edge N. Drop req -> grant=0000 after the next edge.
- Fair rotation: MAX_HOLD=3, req=1111 held 16 cycles -> grant sequence 0001×3, 0010×3, 0100×3, 1000×3, 0001…
- Back-to-back release: holder 0 granted, req=0011 → 0010 at one edge -> grant=0010 after that edge with no zero cycle between. Then req=1000 only -> grant=1000.
- Enable revocation: grant=0010 active, en=0 -> grant=0000 after the next edge. en=1 with req=1111 -> grant=0100, since the pointer has moved past 1.
- Reset mid-grant: grant=1000, rst=1 one cycle with req=1111 -> grant=0000 after the reset edge, then grant=0001 after the following edge.

Source files
------------

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: 4-way round-robin arbiter with bounded hold (clk, rst, en, req[3:0] -> grant[3:0], grant_idx[1:0], grant_valid)
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       grant_valid
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  localparam logic [CNT_W-1:0] LIM = (MAX_HOLD == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_HOLD - 1);
  logic [0:0] state;
  logic [1:0] last, base, pick;
  logic [CNT_W-1:0] hold_cnt;
  logic rotate;
  assign base = (state == IDLE) ? last : grant_idx;
  assign rotate = (MAX_HOLD != 0) && (hold_cnt == LIM) && |(req & ~grant);
  always_comb begin
    pick = base;
    for (int k = 3; k >= 0; k--)
      if (req[base + 2'(k + 1)]) pick = base + 2'(k + 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= 4'b0000;
      grant_idx <= 2'b00;
      grant_valid <= 1'b0;
      last <= 2'd3;
      hold_cnt <= '0;
    end else if (state == IDLE) begin
      if (en && |req) begin
        state <= GRANT;
        grant <= 4'b0001 << pick;
        grant_idx <= pick;
        grant_valid <= 1'b1;
        hold_cnt <= '0;
      end
    end else if (!en) begin
      state <= IDLE;
      grant <= 4'b0000;
      grant_valid <= 1'b0;
      last <= grant_idx;
    end else if (!req[grant_idx] || rotate) begin
      last <= grant_idx;
      hold_cnt <= '0;
      state <= |req ? GRANT : IDLE;
      grant <= |req ? 4'b0001 << pick : 4'b0000;
      grant_idx <= |req ? pick : grant_idx;
      grant_valid <= |req;
    end else if (hold_cnt != LIM) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb_rr_arbiter_4: directed testbench for rr_arbiter_4 with MAX_HOLD=3
module tb_rr_arbiter_4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic grant_valid;
  int pass = 0;
  int total = 0;

  rr_arbiter_4 #(.MAX_HOLD(3), .CNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .req(req),
    .grant(grant),
    .grant_idx(grant_idx),
    .grant_valid(grant_valid)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_idx !== 2'b00)
      $display("FAIL reset_state: got grant=%b valid=%b idx=%b want 0000/0/00", grant, grant_valid, grant_idx);
    else pass++;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_idx !== 2'b00)
        $display("FAIL reset_idle[%0d]: got grant=%b valid=%b idx=%b want 0000/0/00", c, grant, grant_valid, grant_idx);
      else pass++;
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    @(negedge clk);
    total++;
    if (grant !== 4'b0100 || grant_idx !== 2'b10 || grant_valid !== 1'b1)
      $display("FAIL single_grant: got grant=%b idx=%b valid=%b want 0100/10/1", grant, grant_idx, grant_valid);
    else pass++;
    for (int c = 0; c < 8; c++) @(negedge clk);
    total++;
    if (grant !== 4'b0100)
      $display("FAIL single_hold: got %b want 0100", grant);
    else pass++;
    req = 4'b0101;
    @(negedge clk);
    total++;
    if (grant !== 4'b0001 || grant_idx !== 2'b00)
      $display("FAIL saturated_rotate: got grant=%b idx=%b want 0001/00", grant, grant_idx);
    else pass++;
    req = 4'b0000;
    @(negedge clk);
    total++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_idx !== 2'b00)
      $display("FAIL single_drop: got grant=%b valid=%b idx=%b want 0000/0/00", grant, grant_valid, grant_idx);
    else pass++;
  endtask

  task automatic test_rotation();
    logic [3:0] exp;
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      exp = 4'b0001 << ((c / 3) % 4);
      total++;
      if (grant !== exp || grant_valid !== 1'b1)
        $display("FAIL rotation[%0d]: got grant=%b valid=%b want %b/1", c, grant, grant_valid, exp);
      else pass++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 4'b0011;
    @(negedge clk);
    total++;
    if (grant !== 4'b0001)
      $display("FAIL b2b_first: got %b want 0001", grant);
    else pass++;
    req = 4'b0010;
    @(negedge clk);
    total++;
    if (grant !== 4'b0010 || grant_valid !== 1'b1 || grant_idx !== 2'b01)
      $display("FAIL b2b_handover: got grant=%b valid=%b idx=%b want 0010/1/01", grant, grant_valid, grant_idx);
    else pass++;
    req = 4'b1000;
    @(negedge clk);
    total++;
    if (grant !== 4'b1000 || grant_idx !== 2'b11)
      $display("FAIL b2b_next: got grant=%b idx=%b want 1000/11", grant, grant_idx);
    else pass++;
    req = 4'b1010;
    @(negedge clk);
    req = 4'b0010;
    @(negedge clk);
    total++;
    if (grant !== 4'b0010)
      $display("FAIL requeue_release: got %b want 0010", grant);
    else pass++;
    req = 4'b1010;
    @(negedge clk);
    total++;
    if (grant !== 4'b0010)
      $display("FAIL requeue_keep: got %b want 0010", grant);
    else pass++;
  endtask

  task automatic test_enable();
    do_reset();
    req = 4'b0010;
    @(negedge clk);
    total++;
    if (grant !== 4'b0010)
      $display("FAIL en_setup: got %b want 0010", grant);
    else pass++;
    en = 1'b0;
    @(negedge clk);
    total++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_idx !== 2'b01)
      $display("FAIL en_revoke: got grant=%b valid=%b idx=%b want 0000/0/01", grant, grant_valid, grant_idx);
    else pass++;
    req = 4'b1111;
    @(negedge clk);
    total++;
    if (grant !== 4'b0000)
      $display("FAIL en_blocked: got %b want 0000", grant);
    else pass++;
    en = 1'b1;
    @(negedge clk);
    total++;
    if (grant !== 4'b0100 || grant_idx !== 2'b10)
      $display("FAIL en_resume: got grant=%b idx=%b want 0100/10", grant, grant_idx);
    else pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b1000;
    @(negedge clk);
    total++;
    if (grant !== 4'b1000)
      $display("FAIL rmid_setup: got %b want 1000", grant);
    else pass++;
    rst = 1'b1;
    req = 4'b1111;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_idx !== 2'b00)
      $display("FAIL rmid_drop: got grant=%b valid=%b idx=%b want 0000/0/00", grant, grant_valid, grant_idx);
    else pass++;
    @(negedge clk);
    total++;
    if (grant !== 4'b0001 || grant_valid !== 1'b1)
      $display("FAIL rmid_regrant: got grant=%b valid=%b want 0001/1", grant, grant_valid);
    else pass++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_rotation();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
